calc_port_driver: RTL and testbench

Per-port request driver sitting directly upstream of one calculator request port (`reqN_cmd_in`/`reqN_data_in`, `out_respN`/`out_dataN`). It buffers operations offered on a valid/ready interface and serialises each one onto the calculator's two-cycle protocol: command with operand 1, then operand 2. It waits for the calculator's response and returns it on a valid/ready result interface. Four instances, one per calculator port, form the complete stimulus front end.

---
 rtl/calc_port_driver.sv | 204 ++++++++++++++++++++
 tb/tb_calc_port_driver.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/calc_port_driver.sv
// rtl/calc_port_driver.sv - per-port request driver serialising buffered ops onto a calculator port
//
// Buffers {cmd, param1, param2} operations and plays each one onto the
// calculator's two-cycle request protocol. It then waits for the response
// and holds it on a valid/ready result interface. Only one operation is in
// flight at a time, so results come back in acceptance order.
//
// Optional feature: define CALC_DRV_TIMEOUT_EN to give up after
// TIMEOUT_CYCLES cycles in WAIT. The result then reports rsp_timeout=1.
//
// Ports:
//   c_clk, reset                         clock, asynchronous active-high reset
//   op_valid/op_ready, op_cmd,
//   op_param1, op_param2                 operation input handshake
//   req_cmd_out, req_data_out            registered drive to calculator request port
//   out_resp, out_data                   calculator response port
//   rsp_valid/rsp_ready, rsp_resp,
//   rsp_data, rsp_timeout                result output handshake
//   busy                                 FSM not idle
//   fifo_count                           occupied operation buffer entries
module calc_port_driver #(
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                            c_clk,
    input  logic                            reset,
    input  logic                            op_valid,
    output logic                            op_ready,
    input  logic [3:0]                      op_cmd,
    input  logic [31:0]                     op_param1,
    input  logic [31:0]                     op_param2,
    output logic [3:0]                      req_cmd_out,
    output logic [31:0]                     req_data_out,
    input  logic [1:0]                      out_resp,
    input  logic [31:0]                     out_data,
    output logic                            rsp_valid,
    input  logic                            rsp_ready,
    output logic [1:0]                      rsp_resp,
    output logic [31:0]                     rsp_data,
    output logic                            rsp_timeout,
    output logic                            busy,
    output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_count
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(FIFO_DEPTH+1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SEND1,
        S_SEND2,
        S_WAIT,
        S_HOLD
    } state_t;

    state_t state, state_nxt;

    logic [3:0]       fifo_cmd [FIFO_DEPTH];
    logic [31:0]      fifo_p1  [FIFO_DEPTH];
    logic [31:0]      fifo_p2  [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;

    // param2 of the popped op, needed one cycle after the pop
    logic [31:0]      cur_param2;

    logic             push, pop;
    logic [3:0]       cmd_nxt;
    logic [31:0]      data_nxt;
    logic             capture;
    logic             tmo_fire;

    // Readiness looks at the current count only; a same-cycle pop does not
    // make room for a push.
    assign op_ready  = (fifo_count != CNT_W'(FIFO_DEPTH));
    // Zero commands complete the handshake but are never stored.
    assign push      = op_valid && op_ready && (op_cmd != 4'd0);
    assign pop       = (state == S_IDLE) && (fifo_count != '0);
    assign busy      = (state != S_IDLE);
    assign rsp_valid = (state == S_HOLD);

`ifdef CALC_DRV_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES+1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES-1);

    logic [TMO_W-1:0] tmo_cnt;
`else
    logic unused_tmo_cfg;
    assign unused_tmo_cfg = (TIMEOUT_CYCLES > 0);
`endif

    always_comb begin
        state_nxt = state;
        cmd_nxt   = 4'd0;
        data_nxt  = 32'd0;
        capture   = 1'b0;
        tmo_fire  = 1'b0;
        case (state)
            S_IDLE: begin
                if (pop) begin
                    state_nxt = S_SEND1;
                    cmd_nxt   = fifo_cmd[rd_ptr];
                    data_nxt  = fifo_p1[rd_ptr];
                end
            end
            S_SEND1: begin
                state_nxt = S_SEND2;
                data_nxt  = cur_param2;
            end
            S_SEND2: begin
                state_nxt = S_WAIT;
            end
            S_WAIT: begin
                // A response on the expiry edge wins over the timeout.
                if (out_resp != 2'd0) begin
                    capture   = 1'b1;
                    state_nxt = S_HOLD;
                end
`ifdef CALC_DRV_TIMEOUT_EN
                else if (tmo_cnt == TMO_LAST) begin
                    tmo_fire  = 1'b1;
                    state_nxt = S_HOLD;
                end
`endif
            end
            S_HOLD: begin
                if (rsp_ready) begin
                    state_nxt = S_IDLE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge c_clk or posedge reset) begin
        if (reset) begin
            state        <= S_IDLE;
            req_cmd_out  <= 4'd0;
            req_data_out <= 32'd0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            fifo_count   <= '0;
            cur_param2   <= 32'd0;
            rsp_resp     <= 2'd0;
            rsp_data     <= 32'd0;
        end else begin
            state        <= state_nxt;
            req_cmd_out  <= cmd_nxt;
            req_data_out <= data_nxt;
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr     <= rd_ptr + 1'b1;
                cur_param2 <= fifo_p2[rd_ptr];
            end
            if (push && !pop) begin
                fifo_count <= fifo_count + 1'b1;
            end else if (pop && !push) begin
                fifo_count <= fifo_count - 1'b1;
            end
            if (capture) begin
                rsp_resp <= out_resp;
                rsp_data <= out_data;
            end else if (tmo_fire) begin
                rsp_resp <= 2'd0;
                rsp_data <= 32'd0;
            end
        end
    end

    // Storage array carries no reset; validity is tracked by the pointers.
    always_ff @(posedge c_clk) begin
        if (push) begin
            fifo_cmd[wr_ptr] <= op_cmd;
            fifo_p1[wr_ptr]  <= op_param1;
            fifo_p2[wr_ptr]  <= op_param2;
        end
    end

`ifdef CALC_DRV_TIMEOUT_EN
    always_ff @(posedge c_clk or posedge reset) begin
        if (reset) begin
            tmo_cnt     <= '0;
            rsp_timeout <= 1'b0;
        end else begin
            if (state == S_SEND2) begin
                tmo_cnt <= '0;
            end else if (state == S_WAIT) begin
                tmo_cnt <= tmo_cnt + 1'b1;
            end
            if (capture) begin
                rsp_timeout <= 1'b0;
            end else if (tmo_fire) begin
                rsp_timeout <= 1'b1;
            end
        end
    end
`else
    assign rsp_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_calc_port_driver.sv
// tb/tb_calc_port_driver.sv - scoreboard bench for calc_port_driver with a behavioural calculator model
module tb_calc_port_driver;

    logic        c_clk = 1'b0;
    logic        reset = 1'b1;
    logic        op_valid = 1'b0;
    logic        op_ready;
    logic [3:0]  op_cmd = 4'd0;
    logic [31:0] op_param1 = 32'd0;
    logic [31:0] op_param2 = 32'd0;
    logic [3:0]  req_cmd_out;
    logic [31:0] req_data_out;
    logic [1:0]  out_resp = 2'd0;
    logic [31:0] out_data = 32'd0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic [1:0]  rsp_resp;
    logic [31:0] rsp_data;
    logic        rsp_timeout;
    logic        busy;
    logic [2:0]  fifo_count;

    calc_port_driver #(.FIFO_DEPTH(4), .TIMEOUT_CYCLES(16)) dut (
        .c_clk(c_clk), .reset(reset),
        .op_valid(op_valid), .op_ready(op_ready), .op_cmd(op_cmd),
        .op_param1(op_param1), .op_param2(op_param2),
        .req_cmd_out(req_cmd_out), .req_data_out(req_data_out),
        .out_resp(out_resp), .out_data(out_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_resp(rsp_resp),
        .rsp_data(rsp_data), .rsp_timeout(rsp_timeout),
        .busy(busy), .fifo_count(fifo_count)
    );

    always #5 c_clk = ~c_clk;

    int n_checks = 0;
    int n_pass   = 0;

    logic [67:0] port_q[$];   // {cmd, param1, param2} expected on the port
    logic [34:0] rsp_q[$];    // {timeout, resp, data} expected on the result side
    bit          calc_en   = 1'b1;
    int          lat_force = 0;
    bit          rdy_rand  = 1'b0;
    logic [3:0]  cmd_pool [7] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd5, 4'd6, 4'd15};

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Calculator behaviour: arithmetic on known commands, error code otherwise.
    function automatic logic [33:0] calc_ref(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
        case (c)
            4'd1:    return {2'd1, a + b};
            4'd2:    return {2'd1, a - b};
            4'd5:    return {2'd1, a << b[4:0]};
            4'd6:    return {2'd1, a >> b[4:0]};
            default: return {2'd2, a ^ b};
        endcase
    endfunction

    // Call just after a rising edge; returns just after the accepting edge.
    task automatic send_op(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
        int waited = 0;
        bit done = 1'b0;
        op_cmd = c; op_param1 = a; op_param2 = b; op_valid = 1'b1;
        while (!done && waited < 200) begin
            @(negedge c_clk);
            if (op_ready) done = 1'b1;
            @(posedge c_clk);
            waited++;
        end
        #1 op_valid = 1'b0;
        if (!done) begin
            n_checks++;
            $display("FAIL op_accept: op_ready never high within 200 cycles");
        end else if (c != 4'd0) begin
            if (calc_en) begin
                port_q.push_back({c, a, b});
                rsp_q.push_back({1'b0, calc_ref(c, a, b)});
            end else begin
                rsp_q.push_back({1'b1, 2'd0, 32'd0});
            end
        end
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while ((rsp_q.size() != 0 || busy || fifo_count != 3'd0) && n < 3000) begin
            @(posedge c_clk); #1; n++;
        end
        if (n >= 3000) begin
            n_checks++;
            $display("FAIL %s: not drained, %0d results outstanding", name, rsp_q.size());
        end
    endtask

    // Calculator port model: checks the serialised request, then answers.
    initial begin
        logic [67:0] e;
        int lat;
        forever begin
            @(negedge c_clk);
            if (calc_en && req_cmd_out != 4'd0) begin
                if (port_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL port_unexpected: cmd %h data %h", req_cmd_out, req_data_out);
                end else begin
                    e = port_q.pop_front();
                    chk("port_cmd_p1", {req_cmd_out, req_data_out}, {e[67:64], e[63:32]});
                    out_resp = 2'd3; out_data = $urandom;   // must be ignored outside WAIT
                    @(negedge c_clk);
                    chk("port_p2", {req_cmd_out, req_data_out}, {4'd0, e[31:0]});
                    @(negedge c_clk);
                    chk("port_zero", {req_cmd_out, req_data_out}, 36'd0);
                    out_resp = 2'd0; out_data = $urandom;
                    lat = (lat_force != 0) ? lat_force : int'($urandom_range(1, 4));
                    repeat (lat - 1) @(negedge c_clk);
                    {out_resp, out_data} = calc_ref(e[67:64], e[63:32], e[31:0]);
                    @(negedge c_clk);
                    out_resp = 2'd0; out_data = 32'd0;
                end
            end
        end
    end

    // Result monitor: compares each completed handshake with the scoreboard.
    initial begin
        logic [34:0] e;
        forever begin
            @(negedge c_clk);
            if (rsp_valid && rsp_ready) begin
                if (rsp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL rsp_unexpected: got t=%0b r=%0d d=%h", rsp_timeout, rsp_resp, rsp_data);
                end else begin
                    e = rsp_q.pop_front();
                    chk("rsp", {rsp_timeout, rsp_resp, rsp_data}, e);
                end
            end
        end
    end

    initial begin
        forever begin
            @(posedge c_clk); #1;
            if (rdy_rand) rsp_ready = ($urandom_range(0, 3) != 0);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int cyc;
        repeat (2) @(posedge c_clk);
        #1;
        chk("reset_port", {req_cmd_out, req_data_out}, 36'd0);
        chk("reset_status", {rsp_valid, rsp_resp, rsp_data, rsp_timeout, busy, fifo_count, op_ready}, 41'd1);
        @(negedge c_clk) reset = 1'b0;
        @(posedge c_clk); #1;

        // Directed add with a response in the 3rd WAIT cycle
        lat_force = 3;
        send_op(4'd1, 32'd5, 32'd1);
        cyc = 0;
        while (!rsp_valid && cyc < 100) begin @(posedge c_clk); #1; cyc++; end
        chk("t1_latency", cyc, 6);
        wait_drain("t1_drain");
        lat_force = 0;

        // Fill the buffer while the FSM is busy
        send_op(4'd2, $urandom, $urandom);
        for (int i = 0; i < 5; i++) begin
            send_op(cmd_pool[$urandom_range(1, 6)], $urandom, $urandom);
            if (i == 3) chk("t2_full", {op_ready, fifo_count}, {1'b0, 3'd4});
        end
        wait_drain("t2_drain");

        // Back-pressure in HOLD with a further op queued
        rsp_ready = 1'b0;
        send_op(4'd2, 32'd100, 32'd30);
        send_op(4'd6, 32'h80, 32'd3);
        cyc = 0;
        while (!rsp_valid && cyc < 100) begin @(negedge c_clk); cyc++; end
        for (int i = 0; i < 10; i++) begin
            @(negedge c_clk);
            chk("t3_hold", {rsp_valid, rsp_resp, rsp_data, req_cmd_out, fifo_count},
                {1'b1, 2'd1, 32'd70, 4'd0, 3'd1});
        end
        @(posedge c_clk); #1 rsp_ready = 1'b1;
        wait_drain("t3_drain");

        // Randomised traffic with random result back-pressure
        rdy_rand = 1'b1;
        for (int i = 0; i < 24; i++) begin
            send_op(cmd_pool[$urandom_range(0, 6)], $urandom, $urandom);
            repeat ($urandom_range(0, 6)) @(posedge c_clk);
            #1;
        end
        wait_drain("t4_drain");
        rdy_rand = 1'b0;
        @(posedge c_clk); #1 rsp_ready = 1'b1;

        // Zero command is dropped
        send_op(4'd0, 32'h1234, 32'h5678);
        chk("t5_drop_count", fifo_count, 3'd0);
        for (int i = 0; i < 5; i++) begin
            @(negedge c_clk);
            chk("t5_drop_idle", {busy, req_cmd_out}, 5'd0);
        end
        @(posedge c_clk); #1;

        // Reset during SEND2 with two ops queued
        calc_en = 1'b0;
        send_op(4'd1, 32'd1, 32'd2);
        send_op(4'd1, 32'd3, 32'd4);
        send_op(4'd1, 32'd5, 32'd6);
        #2 reset = 1'b1;
        #1;
        chk("t6_rst_port", {req_cmd_out, req_data_out}, 36'd0);
        chk("t6_rst_status", {fifo_count, rsp_valid, busy}, 5'd0);
        @(negedge c_clk) reset = 1'b0;
        port_q.delete();
        rsp_q.delete();
        #1 chk("t6_op_ready", op_ready, 1'b1);
        repeat (20) @(negedge c_clk);
        chk("t6_quiet", {busy, fifo_count, rsp_valid, req_cmd_out}, 9'd0);
        @(posedge c_clk); #1;

        // Calculator never answers
        send_op(4'd5, 32'd7, 32'd8);
`ifdef CALC_DRV_TIMEOUT_EN
        cyc = 0;
        while (!rsp_valid && cyc < 100) begin @(posedge c_clk); #1; cyc++; end
        chk("t7_tmo_latency", cyc, 19);
        wait_drain("t7_drain");
`else
        repeat (40) @(posedge c_clk);
        #1;
        chk("t7_stuck", {busy, rsp_valid}, 2'b10);
        reset = 1'b1;
        @(negedge c_clk) reset = 1'b0;
        rsp_q.delete();
        port_q.delete();
        #1 chk("t7_recover", {busy, fifo_count}, 4'd0);
`endif
        calc_en = 1'b1;
        @(posedge c_clk); #1;

        // Short post-recovery transaction
        send_op(4'd6, 32'hF0, 32'd4);
        wait_drain("t8_drain");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
